// File: rtl/axi_round_clip_multi.sv
// Multi-channel AXI-Stream round-and-saturate stage: S1 rounds off DROP LSBs with a
// per-beat rounding mode, S2 saturates to WIDTH_OUT and counts beats that clipped.
module axi_round_clip_multi #(
    parameter int WIDTH_IN  = 18,
    parameter int WIDTH_OUT = 16,
    parameter int CLIP_BITS = 1,
    parameter int NUM_CH    = 2,
    parameter int CNT_W     = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    mode,
    input  logic                          clear_stats,
    input  logic [NUM_CH*WIDTH_IN-1:0]    i_tdata,
    input  logic                          i_tlast,
    input  logic                          i_tvalid,
    output logic                          i_tready,
    output logic [NUM_CH*WIDTH_OUT-1:0]   o_tdata,
    output logic                          o_tlast,
    output logic                          o_tvalid,
    input  logic                          o_tready,
    output logic [CNT_W-1:0]              sat_count,
    output logic                          sat_flag
);

    localparam int DROP = WIDTH_IN - WIDTH_OUT - CLIP_BITS;
    // One guard bit above the shifted value so a round-up never wraps.
    localparam int RW   = WIDTH_IN - DROP + 1;

    localparam logic [WIDTH_OUT-1:0] MAX_C = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    localparam logic [WIDTH_OUT-1:0] MIN_C = {1'b1, {(WIDTH_OUT-1){1'b0}}};

    // In range when every bit from the result MSB down to the output sign bit agrees.
    function automatic logic clip_f(input logic [RW-1:0] r);
        logic [RW-WIDTH_OUT:0] top;
        top    = r[RW-1:WIDTH_OUT-1];
        clip_f = !((top == '0) || (top == '1));
    endfunction

    function automatic logic [WIDTH_OUT-1:0] sat_f(input logic [RW-1:0] r);
        if (!clip_f(r)) begin
            sat_f = r[WIDTH_OUT-1:0];
        end else if (r[RW-1]) begin
            sat_f = MIN_C;
        end else begin
            sat_f = MAX_C;
        end
    endfunction

    logic [NUM_CH*RW-1:0] rnd_s;

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            logic signed [WIDTH_IN-1:0] x_s;
            logic        [RW-1:0]       r_s;

            assign x_s = i_tdata[k*WIDTH_IN +: WIDTH_IN];
            assign rnd_s[k*RW +: RW] = r_s;

            if (DROP > 0) begin : g_rnd
                logic [WIDTH_IN-DROP-1:0] q_s;
                logic [DROP-1:0]          f_s;
                logic [DROP-1:0]          fsh_s;
                logic                     half_s;
                logic                     inc_s;

                // Floor-shift, then add the mode-dependent round increment.
                always_comb begin
                    q_s    = x_s[WIDTH_IN-1:DROP];
                    f_s    = x_s[DROP-1:0];
                    fsh_s  = f_s << 1'b1;
                    half_s = f_s[DROP-1] & (fsh_s == '0);
                    inc_s  = 1'b0;
                    case (mode)
                        2'd0:    inc_s = 1'b0;
                        2'd1:    inc_s = x_s[WIDTH_IN-1] & (f_s != '0);
                        2'd2:    inc_s = f_s[DROP-1];
                        2'd3:    inc_s = f_s[DROP-1] & (~half_s | q_s[0]);
                        default: inc_s = 1'b0;
                    endcase
                    r_s = {q_s[WIDTH_IN-DROP-1], q_s} + {{(RW-1){1'b0}}, inc_s};
                end
            end else begin : g_byp
                assign r_s = {x_s[WIDTH_IN-1], x_s};
            end
        end
    endgenerate

    logic                          s1_valid_q, s1_valid_d;
    logic                          s1_last_q,  s1_last_d;
    logic [NUM_CH*RW-1:0]          s1_data_q,  s1_data_d;
    logic                          o_valid_q,  o_valid_d;
    logic                          o_last_q,   o_last_d;
    logic [NUM_CH*WIDTH_OUT-1:0]   o_data_q,   o_data_d;
    logic [CNT_W-1:0]              sat_count_q, sat_count_d;
    logic                          sat_flag_q,  sat_flag_d;

    logic                          s2_rdy_s;
    logic                          s1_adv_s;
    logic                          in_rdy_s;
    logic                          acc_s;
    logic                          clip_any_s;
    logic [NUM_CH*WIDTH_OUT-1:0]   sat_data_s;

    // Handshake, pipeline advance, saturation and clip statistics.
    always_comb begin
        s2_rdy_s   = ~o_valid_q | o_tready;
        s1_adv_s   = s1_valid_q & s2_rdy_s;
        in_rdy_s   = ~s1_valid_q | s2_rdy_s;
        acc_s      = i_tvalid & in_rdy_s;

        clip_any_s = 1'b0;
        sat_data_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sat_data_s[c*WIDTH_OUT +: WIDTH_OUT] = sat_f(s1_data_q[c*RW +: RW]);
            clip_any_s = clip_any_s | clip_f(s1_data_q[c*RW +: RW]);
        end

        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_data_d  = s1_data_q;
        if (acc_s) begin
            s1_valid_d = 1'b1;
            s1_last_d  = i_tlast;
            s1_data_d  = rnd_s;
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        o_valid_d = o_valid_q;
        o_last_d  = o_last_q;
        o_data_d  = o_data_q;
        if (s1_adv_s) begin
            o_valid_d = 1'b1;
            o_last_d  = s1_last_q;
            o_data_d  = sat_data_s;
        end else if (o_tready) begin
            o_valid_d = 1'b0;
        end else begin
            o_valid_d = o_valid_q;
        end

        // A clip is counted as its beat enters the output register; clear takes priority.
        sat_count_d = sat_count_q;
        sat_flag_d  = sat_flag_q;
        if (clear_stats) begin
            sat_count_d = '0;
            sat_flag_d  = 1'b0;
        end else if (s1_adv_s && clip_any_s) begin
            sat_flag_d = 1'b1;
            if (sat_count_q != '1) begin
                sat_count_d = sat_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                sat_count_d = sat_count_q;
            end
        end else begin
            sat_count_d = sat_count_q;
        end
    end

    // Pipeline and statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_data_q   <= '0;
            o_valid_q   <= 1'b0;
            o_last_q    <= 1'b0;
            o_data_q    <= '0;
            sat_count_q <= '0;
            sat_flag_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_data_q   <= s1_data_d;
            o_valid_q   <= o_valid_d;
            o_last_q    <= o_last_d;
            o_data_q    <= o_data_d;
            sat_count_q <= sat_count_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    assign i_tready  = in_rdy_s;
    assign o_tdata   = o_data_q;
    assign o_tlast   = o_last_q;
    assign o_tvalid  = o_valid_q;
    assign sat_count = sat_count_q;
    assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_axi_round_clip_multi.sv
// Scoreboard bench for axi_round_clip_multi at default parameters (18->16 bits, 2 channels).
module tb_axi_round_clip_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        clear_stats;
    logic [35:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic [31:0] sat_count;
    logic        sat_flag;

    axi_round_clip_multi dut (
        .clk(clk), .reset(reset), .mode(mode), .clear_stats(clear_stats),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .sat_count(sat_count), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          exp_clip = 0;
    bit          lat_chk = 1'b0;
    bit          last_acc = 1'b0;
    logic [32:0] exp_q[$];
    int          acc_q[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference: floor-shift by 1, mode-specific increment, clamp to 16-bit signed.
    function automatic logic [16:0] model_ch(input logic [17:0] xin, input logic [1:0] md);
        int x, q, f, r;
        logic clip;
        x = int'($signed(xin));
        q = x >>> 1;
        f = x - 2 * q;
        case (md)
            2'd0:    r = q;
            2'd1:    r = (x < 0 && f != 0) ? q + 1 : q;
            2'd2:    r = (2 * f >= 2) ? q + 1 : q;
            default: r = (2 * f > 2) ? q + 1 : ((2 * f == 2) ? q + (q & 1) : q);
        endcase
        clip = 1'b0;
        if (r > 32767) begin
            r = 32767; clip = 1'b1;
        end else if (r < -32768) begin
            r = -32768; clip = 1'b1;
        end
        return {clip, r[15:0]};
    endfunction

    // One clock: sample just before the rising edge, then return on the next falling edge.
    task automatic tick();
        logic [16:0] m0, m1;
        logic [32:0] e;
        int a;
        #4;
        if (o_tvalid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", 64'(o_tvalid), 64'd0);
            end else if (o_tready) begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check_eq("data", 64'(o_tdata), 64'(e[31:0]));
                check_eq("tlast", 64'(o_tlast), 64'(e[32]));
                if (lat_chk) check_eq("latency", 64'(cyc - a), 64'd2);
            end else begin
                check_eq("stall_hold", 64'({o_tlast, o_tdata}), 64'(exp_q[0]));
            end
        end
        last_acc = i_tvalid && i_tready;
        if (last_acc) begin
            m0 = model_ch(i_tdata[17:0], mode);
            m1 = model_ch(i_tdata[35:18], mode);
            exp_q.push_back({i_tlast, m1[15:0], m0[15:0]});
            acc_q.push_back(cyc);
            if (m0[16] || m1[16]) exp_clip++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive_beat(input logic [17:0] a, input logic [17:0] b, input logic l,
                              input logic [1:0] md);
        int g;
        i_tdata = {b, a}; i_tlast = l; mode = md; i_tvalid = 1'b1;
        g = 0;
        do begin
            tick();
            g++;
        end while (!last_acc && g < 100);
        if (!last_acc) check_eq("accept_timeout", 64'd0, 64'd1);
        i_tvalid = 1'b0;
    endtask

    task automatic drain();
        int g;
        i_tvalid = 1'b0; o_tready = 1'b1;
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            tick();
            g++;
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    task automatic check_stats(input string tag);
        check_eq({tag, "_count"}, 64'(sat_count), 64'(exp_clip));
        check_eq({tag, "_flag"}, 64'(sat_flag), 64'(exp_clip != 0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, guard;
        reset = 1'b1; mode = 2'd0; clear_stats = 1'b0; i_tdata = '0; i_tlast = 1'b0;
        i_tvalid = 1'b0; o_tready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 64'(o_tvalid), 64'd0);
        check_eq("rst_data", 64'(o_tdata), 64'd0);
        check_eq("rst_last", 64'(o_tlast), 64'd0);
        check_eq("rst_count", 64'(sat_count), 64'd0);
        check_eq("rst_flag", 64'(sat_flag), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Rounding modes, back-to-back, exact two-cycle latency.
        lat_chk = 1'b1;
        for (int m = 0; m < 4; m++) drive_beat(18'sd5, -18'sd5, 1'b0, 2'(m));
        drive_beat(18'sd7, -18'sd7, 1'b1, 2'd3);
        drain();
        lat_chk = 1'b0;
        check_stats("no_clip");

        // Saturation and clip counting.
        drive_beat(18'sd70000, -18'sd70000, 1'b0, 2'd0);
        drain();
        check_eq("clip1_count", 64'(sat_count), 64'd1);
        check_stats("clip1");
        drive_beat(18'sd65535, 18'sd0, 1'b1, 2'd2);
        drain();
        check_stats("clip2");

        // Random stream with random backpressure.
        sent = 0; guard = 0;
        while (sent < 1000 && guard < 20000) begin
            if (!i_tvalid && $urandom_range(0, 3) != 0) begin
                i_tdata = {18'($urandom), 18'(sent)};
                i_tlast = (sent % 8 == 7);
                mode = 2'($urandom_range(0, 3));
                i_tvalid = 1'b1;
            end
            o_tready = 1'($urandom_range(0, 1));
            tick();
            if (last_acc) begin
                sent++;
                i_tvalid = 1'b0;
            end
            guard++;
        end
        check_eq("stream_sent", 64'(sent), 64'd1000);
        drain();
        check_stats("stream");

        // Mode toggling with a full, stalled pipe.
        o_tready = 1'b0;
        drive_beat(18'sd5, -18'sd3, 1'b0, 2'd0);
        drive_beat(18'sd5, -18'sd3, 1'b0, 2'd1);
        i_tdata = {-18'sd11, 18'sd9}; i_tvalid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            mode = 2'(s);
            tick();
        end
        mode = 2'd2;
        o_tready = 1'b1;
        guard = 0;
        do begin tick(); guard++; end while (!last_acc && guard < 20);
        i_tvalid = 1'b0;
        for (int m = 3; m < 7; m++) drive_beat(18'sd7, -18'sd7, 1'b0, 2'(m));
        drain();

        // Clear in the same cycle the clipping beat enters the output register.
        drive_beat(18'sd100000, 18'sd0, 1'b0, 2'd0);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        exp_clip = 0;
        drain();
        check_stats("clear_win");
        drive_beat(-18'sd100000, 18'sd1, 1'b0, 2'd0);
        drain();
        check_eq("after_clear_count", 64'(sat_count), 64'd1);

        // Reset with two beats in flight.
        o_tready = 1'b0;
        drive_beat(18'sd90000, 18'sd2, 1'b0, 2'd0);
        drive_beat(18'sd4, 18'sd6, 1'b0, 2'd0);
        check_eq("pre_reset_count", 64'(sat_count), 64'(exp_clip));
        reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", 64'(o_tvalid), 64'd0);
        check_eq("mid_rst_count", 64'(sat_count), 64'd0);
        check_eq("mid_rst_flag", 64'(sat_flag), 64'd0);
        exp_q.delete(); acc_q.delete(); exp_clip = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        o_tready = 1'b1;
        @(negedge clk);
        drive_beat(18'sd3, -18'sd1, 1'b0, 2'd2);
        drive_beat(18'sd21, -18'sd21, 1'b0, 2'd1);
        drive_beat(18'sd131071, 18'sd8, 1'b1, 2'd3);
        drain();
        check_stats("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
